// File: rtl/wh_bram_reader_if.sv
// rtl/wh_bram_reader_if.sv - WH entry stream from the BRAM reader to its consumer
interface wh_bram_reader_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int W_NUM_OF_COLS  = 16,
    parameter int NUM_NODE_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]     feat_o [0:W_NUM_OF_COLS-1];
    logic [NUM_NODE_WIDTH-1:0] num_of_nodes_o;
    logic                      source_node_flag_o;
    logic                      last_o;
    logic                      valid_o;
    logic                      ready_i;

    modport master (
        output feat_o, num_of_nodes_o, source_node_flag_o, last_o, valid_o,
        input  ready_i
    );

    modport slave (
        input  feat_o, num_of_nodes_o, source_node_flag_o, last_o, valid_o,
        output ready_i
    );
endinterface

// File: rtl/wh_bram_reader.sv
// rtl/wh_bram_reader.sv - streams WH entries out of BRAM behind the writer, 2-deep skid FIFO
// Optional framing check: define WH_READER_FRAME_CHECK_EN.
module wh_bram_reader #(
    parameter int DATA_WIDTH      = 8,
    parameter int W_NUM_OF_COLS   = 16,
    parameter int NUM_OF_NODES    = 168,
    parameter int NUM_OF_ENTRIES  = 13264,
    parameter int BRAM_ADDR_WIDTH = 32,
    localparam int NUM_NODE_WIDTH = $clog2(NUM_OF_NODES),
    localparam int WH_BRAM_WIDTH  = DATA_WIDTH*W_NUM_OF_COLS + NUM_NODE_WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [BRAM_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WH_BRAM_WIDTH-1:0]   WH_BRAM_doutb,
    output logic                       WH_BRAM_enb,
    output logic [BRAM_ADDR_WIDTH-1:0] WH_BRAM_addrb,
    wh_bram_reader_if.master           out_if,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);
    localparam int CNT_W = $clog2(NUM_OF_ENTRIES + 1);
    localparam logic [BRAM_ADDR_WIDTH-1:0] ENTRIES_A = BRAM_ADDR_WIDTH'(NUM_OF_ENTRIES);
    localparam logic [CNT_W-1:0]           ENTRIES_C = CNT_W'(NUM_OF_ENTRIES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state_q, state_d;
    logic [BRAM_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]           dlv_cnt_q, dlv_cnt_d;
    logic [NUM_NODE_WIDTH-1:0]  grp_cnt_q, grp_cnt_d;
    logic                       inflight_q, inflight_d;
    logic [WH_BRAM_WIDTH-1:0]   fifo_q [2];
    logic [WH_BRAM_WIDTH-1:0]   fifo_d [2];
    logic                       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]                 fifo_cnt_q, fifo_cnt_d;

    logic [WH_BRAM_WIDTH-1:0]   head;
    logic                       valid, pop, push, issue, last;
    logic [1:0]                 occ;
    logic [NUM_NODE_WIDTH:0]    grp_need, grp_next;

    assign valid    = (fifo_cnt_q != 2'd0);
    assign head     = valid ? fifo_q[rd_ptr_q] : '0;
    assign pop      = valid & out_if.ready_i;
    assign push     = inflight_q;
    // Slots already promised: buffered + in flight, minus the one leaving this cycle.
    assign occ      = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    assign issue    = (state_q == RUN) && (rd_addr_q < wr_addr_i) &&
                      (rd_addr_q < ENTRIES_A) && (occ < 2'd2);

    assign grp_need = (out_if.num_of_nodes_o == '0) ? (NUM_NODE_WIDTH+1)'(1)
                                                    : {1'b0, out_if.num_of_nodes_o};
    assign grp_next = {1'b0, grp_cnt_q} + (NUM_NODE_WIDTH+1)'(1);
    assign last     = valid & (grp_next >= grp_need);

    always_comb begin
        for (int i = 0; i < W_NUM_OF_COLS; i++) begin
            out_if.feat_o[i] = head[WH_BRAM_WIDTH-1-i*DATA_WIDTH -: DATA_WIDTH];
        end
    end

    assign out_if.num_of_nodes_o     = head[NUM_NODE_WIDTH:1];
    assign out_if.source_node_flag_o = head[0];
    assign out_if.last_o             = last;
    assign out_if.valid_o            = valid;

    assign WH_BRAM_enb   = issue;
    assign WH_BRAM_addrb = issue ? rd_addr_q : '0;
    assign busy_o        = (state_q == RUN) || (state_q == DONE);
    assign done_o        = (state_q == DONE);

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        dlv_cnt_d  = dlv_cnt_q;
        grp_cnt_d  = grp_cnt_q;
        inflight_d = issue;
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

        if (push) begin
            fifo_d[wr_ptr_q] = WH_BRAM_doutb;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d  = ~rd_ptr_q;
            dlv_cnt_d = dlv_cnt_q + CNT_W'(1);
            grp_cnt_d = last ? '0 : grp_next[NUM_NODE_WIDTH-1:0];
        end
        if (issue) begin
            rd_addr_d = rd_addr_q + BRAM_ADDR_WIDTH'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = RUN;
                    rd_addr_d = '0;
                    dlv_cnt_d = '0;
                    grp_cnt_d = '0;
                end
            end
            RUN:     if (dlv_cnt_d == ENTRIES_C) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            dlv_cnt_q  <= '0;
            grp_cnt_q  <= '0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            dlv_cnt_q  <= dlv_cnt_d;
            grp_cnt_q  <= grp_cnt_d;
            inflight_q <= inflight_d;
            fifo_q     <= fifo_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

`ifdef WH_READER_FRAME_CHECK_EN
    // A subgraph must open with its source node and carry no other source flags.
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (pop && (head[0] != (grp_cnt_q == '0))) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_wh_bram_reader.sv
// tb/tb_wh_bram_reader.sv - scoreboard bench for wh_bram_reader with a BRAM model
`timescale 1ns/1ps
module tb_wh_bram_reader;
    localparam int DW    = 8;
    localparam int COLS  = 4;
    localparam int NODES = 8;
    localparam int N     = 4;
    localparam int AW    = 16;
    localparam int NW    = $clog2(NODES);
    localparam int BW    = DW*COLS + NW + 1;

    typedef struct packed {
        logic [BW-1:0] word;
        logic          last;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [BW-1:0] doutb = '0;
    logic          enb, busy, done, err;
    logic [AW-1:0] addrb;
    logic [BW-1:0] mem [N];

    exp_t          sb [$];
    exp_t          e;
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            last_xfer_cyc = -10;
    int            n_issue = 0;
    int            n_last = 0;
    logic [AW-1:0] exp_addr = '0;
    logic          done_seen = 1'b0;
    logic          err_now = 1'b0;
    logic          err_acc = 1'b0;

    wh_bram_reader_if #(.DATA_WIDTH(DW), .W_NUM_OF_COLS(COLS), .NUM_NODE_WIDTH(NW)) out_if ();

    wh_bram_reader #(
        .DATA_WIDTH(DW), .W_NUM_OF_COLS(COLS), .NUM_OF_NODES(NODES),
        .NUM_OF_ENTRIES(N), .BRAM_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .wr_addr_i(wr_addr),
        .WH_BRAM_doutb(doutb), .WH_BRAM_enb(enb), .WH_BRAM_addrb(addrb),
        .out_if(out_if), .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (enb && int'(addrb) < N) doutb <= mem[int'(addrb)];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (enb) begin
                check("rd_addr_order", 64'(addrb), 64'(exp_addr));
                check("rd_behind_writer", 64'(addrb < wr_addr), 64'd1);
                check("rd_in_range", 64'(int'(addrb) < N), 64'd1);
                exp_addr = exp_addr + 1'b1;
                n_issue++;
            end
            if (out_if.valid_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    e = sb[0];
                    for (int i = 0; i < COLS; i++)
                        check("feat", 64'(out_if.feat_o[i]), 64'(e.word[BW-1-i*DW -: DW]));
                    check("num_of_nodes", 64'(out_if.num_of_nodes_o), 64'(e.word[NW:1]));
                    check("source_flag", 64'(out_if.source_node_flag_o), 64'(e.word[0]));
                    check("last", 64'(out_if.last_o), 64'(e.last));
                    if (out_if.ready_i) begin
                        void'(sb.pop_front());
                        last_xfer_cyc = cyc;
                        if (out_if.last_o) n_last++;
                    end
                end
            end else begin
                check("last_without_valid", 64'(out_if.last_o), 64'd0);
            end
            check("err", 64'(err), 64'(err_now));
            if (out_if.valid_o && out_if.ready_i && sb.size() >= 0) err_now = e.err;
            if (done) begin
                check("done_timing", 64'(cyc), 64'(last_xfer_cyc + 1));
                check("done_sb_empty", 64'(sb.size()), 64'd0);
                check("busy_in_done", 64'(busy), 64'd1);
                done_seen = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        sb.delete();
        err_acc = 1'b0;
        err_now = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Expected stream for one pass: entries in address order, group position per subgraph.
    task automatic push_pass();
        int   pos = 0;
        int   need;
        exp_t x;
        for (int i = 0; i < N; i++) begin
            need   = (mem[i][NW:1] == 0) ? 1 : int'(mem[i][NW:1]);
            x.word = mem[i];
            x.last = (pos + 1 >= need);
`ifdef WH_READER_FRAME_CHECK_EN
            if (mem[i][0] != (pos == 0)) err_acc = 1'b1;
`endif
            x.err  = err_acc;
            sb.push_back(x);
            pos = x.last ? 0 : pos + 1;
        end
    endtask

    task automatic start_pass();
        push_pass();
        exp_addr  = '0;
        done_seen = 1'b0;
        n_issue   = 0;
        n_last    = 0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd_ready, input bit rnd_wr);
        int i = 0;
        while (!done_seen && i < budget) begin
            if (rnd_ready) out_if.ready_i = ($urandom_range(0, 3) != 0);
            if (rnd_wr && int'(wr_addr) < N && $urandom_range(0, 2) == 0) wr_addr = wr_addr + 1'b1;
            tick();
            i++;
        end
        check("pass_done", 64'(done_seen), 64'd1);
        check("sb_drained", 64'(sb.size()), 64'd0);
        out_if.ready_i = 1'b1;
        if (!done_seen) do_reset();
        tick();
        tick();
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) mem[i] = BW'({$urandom(), $urandom()});
    endtask

    initial begin
        out_if.ready_i = 1'b0;
        fill_random();
        do_reset();
        @(negedge clk);
        check("rst_enb", 64'(enb), 64'd0);
        check("rst_addrb", 64'(addrb), 64'd0);
        check("rst_valid", 64'(out_if.valid_o), 64'd0);
        check("rst_last", 64'(out_if.last_o), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_feat0", 64'(out_if.feat_o[0]), 64'd0);
        check("rst_nodes", 64'(out_if.num_of_nodes_o), 64'd0);
        tick();

        // Back-to-back pass: reads on consecutive cycles, data two cycles after first read.
        fill_random();
        out_if.ready_i = 1'b1;
        wr_addr = AW'(N);
        start_pass();
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            check("a_enb", 64'(enb), 64'd1);
            check("a_addrb", 64'(addrb), 64'(k));
            check("a_busy", 64'(busy), 64'd1);
            if (k == 1) check("a_valid_early", 64'(out_if.valid_o), 64'd0);
            if (k == 2) check("a_valid_first", 64'(out_if.valid_o), 64'd1);
            tick();
        end
        wait_done(50, 1'b0, 1'b0);

        // Writer stall: only one entry available for ten cycles.
        fill_random();
        wr_addr = AW'(1);
        start_pass();
        repeat (10) tick();
        check("b_one_delivered", 64'(sb.size()), 64'(N - 1));
        wr_addr = AW'(3);
        repeat (6) tick();
        check("b_three_delivered", 64'(sb.size()), 64'(N - 3));
        wr_addr = AW'(N);
        wait_done(50, 1'b0, 1'b0);

        // Downstream stall: buffer fills to two and holds.
        fill_random();
        out_if.ready_i = 1'b0;
        start_pass();
        repeat (7) tick();
        @(negedge clk);
        check("c_issued_while_stalled", 64'(n_issue), 64'd2);
        check("c_valid_held", 64'(out_if.valid_o), 64'd1);
        tick();
        out_if.ready_i = 1'b1;
        wait_done(50, 1'b0, 1'b0);

        // Subgraph framing: group of three, then a single-node group.
        mem[0] = {32'($urandom()), NW'(3), 1'b1};
        mem[1] = {32'($urandom()), NW'(3), 1'b0};
        mem[2] = {32'($urandom()), NW'(3), 1'b0};
        mem[3] = {32'($urandom()), NW'(1), 1'b1};
        start_pass();
        wait_done(50, 1'b0, 1'b0);
        check("d_last_count", 64'(n_last), 64'd2);

        // Reset with a read in flight: returned data must be dropped.
        fill_random();
        start_pass();
        rst = 1'b1;
        sb.delete();
        err_acc = 1'b0;
        err_now = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("e_inflight_dropped", 64'(out_if.valid_o), 64'd0);
        check("e_idle_busy", 64'(busy), 64'd0);
        tick();

        // Reset with a full buffer, then restart from address zero.
        fill_random();
        out_if.ready_i = 1'b0;
        start_pass();
        repeat (5) tick();
        rst = 1'b1;
        sb.delete();
        err_acc = 1'b0;
        err_now = 1'b0;
        tick();
        @(negedge clk);
        check("e_rst_valid", 64'(out_if.valid_o), 64'd0);
        check("e_rst_busy", 64'(busy), 64'd0);
        tick();
        rst = 1'b0;
        out_if.ready_i = 1'b1;
        fill_random();
        start_pass();
        wait_done(50, 1'b0, 1'b0);

        // Random contents, writer progress and backpressure.
        for (int p = 0; p < 25; p++) begin
            fill_random();
            wr_addr = AW'($urandom_range(0, N));
            out_if.ready_i = ($urandom_range(0, 1) != 0);
            start_pass();
            wait_done(300, 1'b1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end
endmodule
